// File: rtl/uart_pkg.sv
// Shared UART types, oversampling constant and baud divisor helper.
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ODD  = 2'd1,
        EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    localparam int OVERSAMPLE = 16;

    function automatic int calc_div(input int clock, input int baud);
        return (baud > 0) ? clock / baud : 0;
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running divider: tick_o is high for one cycle every DIV clocks; clr_i restarts the count.
// Tick is decoded straight from the count, no backpressure.
module uart_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic tick_o
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        if (clr_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_n.sv
// Full-duplex UART: DATA_BITS data, optional parity, 1/2 stop bits, 16x oversampled receiver.
// txStart is a level request taken only when the transmitter is idle; the receiver has no backpressure.
module uart_n
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxEn,
    input  logic                 rxIn,
    output logic                 rxBusy,
    output logic                 rxDone,
    output logic                 rxErr,
    output logic                 rxParErr,
    output logic                 rxBreak,
    output logic [DATA_BITS-1:0] rxOut,
    input  logic                 txEn,
    input  logic                 txStart,
    input  logic [DATA_BITS-1:0] txIn,
    output logic                 txBusy,
    output logic                 txDone,
    output logic                 txOut
);

    localparam int         TX_DIV   = calc_div(CLOCK_RATE, BAUD_RATE);
    localparam int         RX_DIV   = calc_div(CLOCK_RATE, BAUD_RATE * OVERSAMPLE);
    localparam parity_e    PAR_MODE = parity_e'(PARITY[1:0]);
    localparam logic       PAR_ON   = (PAR_MODE != NONE);
    localparam logic       PAR_ODD  = (PAR_MODE == ODD);
    localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] OS_MID   = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] OS_END   = 4'(OVERSAMPLE - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_data_bits
        $error("uart_n: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_err_parity
        $error("uart_n: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_err_stop_bits
        $error("uart_n: STOP_BITS must be 1 or 2");
    end
    if (RX_DIV < 1) begin : g_err_rx_div
        $error("uart_n: clock too slow for 16x oversampling at this baud rate");
    end

    // ---------------- transmitter ----------------
    tx_state_e            tx_state_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic [3:0]           tx_bit_q;
    logic                 tx_stop_q;
    logic                 tx_par_q;
    logic                 tx_out_q;
    logic                 tx_busy_q;
    logic                 tx_done_q;
    logic                 tx_tick;

    uart_tick_gen #(.DIV(TX_DIV)) u_tx_tick (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (tx_state_q == TX_IDLE),
        .tick_o (tx_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_par_q   <= 1'b0;
            tx_out_q   <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            if (!txEn) begin
                tx_state_q <= TX_IDLE;
                tx_out_q   <= 1'b1;
                tx_busy_q  <= 1'b0;
            end else begin
                case (tx_state_q)
                    TX_IDLE: if (txStart) begin
                        tx_state_q <= TX_START;
                        tx_shift_q <= txIn;
                        tx_par_q   <= (^txIn) ^ PAR_ODD;
                        tx_out_q   <= 1'b0;
                        tx_busy_q  <= 1'b1;
                    end
                    TX_START: if (tx_tick) begin
                        tx_state_q <= TX_DATA;
                        tx_bit_q   <= '0;
                        tx_out_q   <= tx_shift_q[0];
                    end
                    TX_DATA: if (tx_tick) begin
                        if (tx_bit_q == BIT_LAST) begin
                            tx_state_q <= PAR_ON ? TX_PARITY : TX_STOP;
                            tx_out_q   <= PAR_ON ? tx_par_q : 1'b1;
                            tx_stop_q  <= 1'b0;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 4'd1;
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_out_q   <= tx_shift_q[1];
                        end
                    end
                    TX_PARITY: if (tx_tick) begin
                        tx_state_q <= TX_STOP;
                        tx_out_q   <= 1'b1;
                        tx_stop_q  <= 1'b0;
                    end
                    TX_STOP: if (tx_tick) begin
                        if (STOP_BITS == 1 || tx_stop_q) begin
                            tx_state_q <= TX_IDLE;
                            tx_busy_q  <= 1'b0;
                            tx_done_q  <= 1'b1;
                        end else begin
                            tx_stop_q <= 1'b1;
                        end
                    end
                    default: begin
                        tx_state_q <= TX_IDLE;
                        tx_out_q   <= 1'b1;
                        tx_busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign txOut  = tx_out_q;
    assign txBusy = tx_busy_q;
    assign txDone = tx_done_q;

    // ---------------- receiver ----------------
    logic                 sync1_q;
    logic                 sync2_q;
    rx_state_e            rx_state_q;
    logic [3:0]           os_cnt_q;
    logic [3:0]           rx_bit_q;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_par_q;
    logic                 rx_busy_q;
    logic                 rx_done_q;
    logic                 rx_err_q;
    logic                 rx_par_err_q;
    logic                 rx_brk_q;
    logic [DATA_BITS-1:0] rx_out_q;
    logic                 rx_tick;
    logic                 os_hit;
    logic                 rx_exp_par;

    uart_tick_gen #(.DIV((RX_DIV < 1) ? 1 : RX_DIV)) u_rx_tick (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (!rxEn),
        .tick_o (rx_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rxIn;
            sync2_q <= sync1_q;
        end
    end

    // Start bit is qualified at its middle; every later bit is sampled a full bit after that.
    assign os_hit     = (rx_state_q == RX_START) ? (os_cnt_q == OS_MID) : (os_cnt_q == OS_END);
    assign rx_exp_par = (^rx_shift_q) ^ PAR_ODD;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q   <= RX_IDLE;
            os_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_q     <= 1'b0;
            rx_busy_q    <= 1'b0;
            rx_done_q    <= 1'b0;
            rx_err_q     <= 1'b0;
            rx_par_err_q <= 1'b0;
            rx_brk_q     <= 1'b0;
            rx_out_q     <= '0;
        end else begin
            rx_done_q <= 1'b0;
            if (!rxEn) begin
                rx_state_q <= RX_IDLE;
                rx_busy_q  <= 1'b0;
            end else if (rx_tick) begin
                if (rx_state_q != RX_IDLE) begin
                    os_cnt_q <= os_hit ? 4'd0 : os_cnt_q + 4'd1;
                end
                case (rx_state_q)
                    RX_IDLE: if (!sync2_q) begin
                        rx_state_q <= RX_START;
                        rx_busy_q  <= 1'b1;
                        os_cnt_q   <= '0;
                    end
                    RX_START: if (os_hit) begin
                        if (sync2_q) begin
                            rx_state_q <= RX_IDLE;
                            rx_busy_q  <= 1'b0;
                        end else begin
                            rx_state_q <= RX_DATA;
                            rx_bit_q   <= '0;
                        end
                    end
                    RX_DATA: if (os_hit) begin
                        rx_shift_q <= {sync2_q, rx_shift_q[DATA_BITS-1:1]};
                        if (rx_bit_q == BIT_LAST) begin
                            rx_state_q <= PAR_ON ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 4'd1;
                        end
                    end
                    RX_PARITY: if (os_hit) begin
                        rx_par_q   <= sync2_q;
                        rx_state_q <= RX_STOP;
                    end
                    RX_STOP: if (os_hit) begin
                        rx_state_q   <= RX_IDLE;
                        rx_busy_q    <= 1'b0;
                        rx_done_q    <= 1'b1;
                        rx_out_q     <= rx_shift_q;
                        rx_err_q     <= !sync2_q;
                        rx_par_err_q <= PAR_ON && (rx_par_q != rx_exp_par);
                        rx_brk_q     <= !sync2_q && (rx_shift_q == '0) && !(PAR_ON && rx_par_q);
                    end
                    default: begin
                        rx_state_q <= RX_IDLE;
                        rx_busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rxBusy   = rx_busy_q;
    assign rxDone   = rx_done_q;
    assign rxErr    = rx_err_q;
    assign rxParErr = rx_par_err_q;
    assign rxBreak  = rx_brk_q;
    assign rxOut    = rx_out_q;

endmodule

// File: tb/tb_uart_n.sv
// Directed bench: slow 8N1 loopback instance plus a fast 8E1 instance for error, break and reset cases.
module tb_uart_n;

    localparam int S_TXDIV = 1250;   // 12 MHz / 9600
    localparam int F_TXDIV = 32;     // 3.2 MHz / 100 kbaud, RX_DIV = 2

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // slow instance, loopback
    logic       s_rst, s_rxEn, s_txEn, s_txStart;
    logic [7:0] s_txIn, s_rxOut;
    logic       s_rxBusy, s_rxDone, s_rxErr, s_rxParErr, s_rxBreak;
    logic       s_txBusy, s_txDone, s_txOut;

    uart_n #(.CLOCK_RATE(12000000), .BAUD_RATE(9600), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_slow (
        .clk(clk), .reset(s_rst), .rxEn(s_rxEn), .rxIn(s_txOut),
        .rxBusy(s_rxBusy), .rxDone(s_rxDone), .rxErr(s_rxErr), .rxParErr(s_rxParErr),
        .rxBreak(s_rxBreak), .rxOut(s_rxOut), .txEn(s_txEn), .txStart(s_txStart),
        .txIn(s_txIn), .txBusy(s_txBusy), .txDone(s_txDone), .txOut(s_txOut)
    );

    // fast instance, even parity, rx from loopback or bench driver
    logic       f_rst, f_rxEn, f_txEn, f_txStart, f_loop, f_drive, f_rxIn;
    logic [7:0] f_txIn, f_rxOut;
    logic       f_rxBusy, f_rxDone, f_rxErr, f_rxParErr, f_rxBreak;
    logic       f_txBusy, f_txDone, f_txOut;

    assign f_rxIn = f_loop ? f_txOut : f_drive;

    uart_n #(.CLOCK_RATE(3200000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_fast (
        .clk(clk), .reset(f_rst), .rxEn(f_rxEn), .rxIn(f_rxIn),
        .rxBusy(f_rxBusy), .rxDone(f_rxDone), .rxErr(f_rxErr), .rxParErr(f_rxParErr),
        .rxBreak(f_rxBreak), .rxOut(f_rxOut), .txEn(f_txEn), .txStart(f_txStart),
        .txIn(f_txIn), .txBusy(f_txBusy), .txDone(f_txDone), .txOut(f_txOut)
    );

    // received-frame logs: data and {err, parErr, break}
    int         s_rx_cnt = 0;
    int         f_rx_cnt = 0;
    logic [7:0] s_rx_dat [16];
    logic [7:0] f_rx_dat [16];
    logic [2:0] f_rx_flg [16];
    logic [2:0] s_rx_flg [16];

    always @(negedge clk) begin
        if (s_rxDone === 1'b1) begin
            s_rx_dat[s_rx_cnt % 16] = s_rxOut;
            s_rx_flg[s_rx_cnt % 16] = {s_rxErr, s_rxParErr, s_rxBreak};
            s_rx_cnt++;
        end
        if (f_rxDone === 1'b1) begin
            f_rx_dat[f_rx_cnt % 16] = f_rxOut;
            f_rx_flg[f_rx_cnt % 16] = {f_rxErr, f_rxParErr, f_rxBreak};
            f_rx_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_txdone(input bit fast, input int budget, output int n);
        n = 0;
        while (!(fast ? f_txDone : s_txDone) && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_rx(input bit fast, input int target, input int budget);
        int n = 0;
        while ((fast ? f_rx_cnt : s_rx_cnt) < target && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic launch(input bit fast, input logic [7:0] d);
        if (fast) begin f_txIn = d; f_txStart = 1'b1; end
        else      begin s_txIn = d; s_txStart = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        f_txStart = 1'b0;
        s_txStart = 1'b0;
    endtask

    task automatic f_send(input logic [7:0] d, input logic p, input logic stp);
        f_drive = 1'b0;
        repeat (F_TXDIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            f_drive = d[i];
            repeat (F_TXDIV) @(negedge clk);
        end
        f_drive = p;
        repeat (F_TXDIV) @(negedge clk);
        f_drive = stp;
        repeat (F_TXDIV) @(negedge clk);
        f_drive = 1'b1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int low_n;
        logic busy_seen;

        s_rst = 1'b1; s_rxEn = 1'b1; s_txEn = 1'b1; s_txStart = 1'b0; s_txIn = '0;
        f_rst = 1'b1; f_rxEn = 1'b1; f_txEn = 1'b1; f_txStart = 1'b0; f_txIn = '0;
        f_loop = 1'b1; f_drive = 1'b1;
        repeat (3) @(negedge clk);

        // reset state: {txOut, txBusy, txDone, rxBusy, rxDone, rxErr, rxParErr, rxBreak}
        check("s_reset_flags", {s_txOut, s_txBusy, s_txDone, s_rxBusy, s_rxDone, s_rxErr, s_rxParErr, s_rxBreak}, 8'h80);
        check("s_reset_rxOut", s_rxOut, 8'h00);
        check("f_reset_flags", {f_txOut, f_txBusy, f_txDone, f_rxBusy, f_rxDone, f_rxErr, f_rxParErr, f_rxBreak}, 8'h80);
        s_rst = 1'b0;
        f_rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: 8N1 loopback, 0x7A
        base = s_rx_cnt;
        launch(1'b0, 8'h7A);
        check("t1_first_cycle", {s_txOut, s_txBusy}, 2'b01);
        wait_txdone(1'b0, 13000, n);
        check("t1_txdone_latency", n, 10 * S_TXDIV);
        check("t1_busy_at_done", s_txBusy, 1'b0);
        wait_rx(1'b0, base + 1, 2000);
        check("t1_rx_count", s_rx_cnt, base + 1);
        check("t1_rx_data", s_rx_dat[base % 16], 8'h7A);
        check("t1_rx_flags", s_rx_flg[base % 16], 3'b000);
        repeat (100) @(negedge clk);

        // 2: txStart held high, back-to-back 0x7A then 0xB1
        base = s_rx_cnt;
        s_txIn = 8'h7A;
        s_txStart = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wait_txdone(1'b0, 13000, n);
        check("t2_first_latency", n, 10 * S_TXDIV);
        s_txIn = 8'hB1;
        @(negedge clk);
        check("t2_b2b_start_bit", {s_txOut, s_txBusy}, 2'b01);
        s_txStart = 1'b0;
        wait_txdone(1'b0, 13000, n);
        check("t2_second_latency", n, 10 * S_TXDIV);
        wait_rx(1'b0, base + 2, 2000);
        check("t2_rx_count", s_rx_cnt, base + 2);
        check("t2_rx_data0", s_rx_dat[base % 16], 8'h7A);
        check("t2_rx_data1", s_rx_dat[(base + 1) % 16], 8'hB1);
        check("t2_rx_flags1", s_rx_flg[(base + 1) % 16], 3'b000);

        // 3: even parity loopback of 0xB1 (four ones -> parity bit 0)
        base = f_rx_cnt;
        launch(1'b1, 8'hB1);
        repeat (9 * F_TXDIV + F_TXDIV / 2) @(negedge clk);
        check("t3_tx_parity_bit", f_txOut, 1'b0);
        wait_txdone(1'b1, 200, n);
        check("t3_txdone_latency", n + 9 * F_TXDIV + F_TXDIV / 2, 11 * F_TXDIV);
        wait_rx(1'b1, base + 1, 100);
        check("t3_rx_count", f_rx_cnt, base + 1);
        check("t3_rx_data", f_rx_dat[base % 16], 8'hB1);
        check("t3_rx_flags", f_rx_flg[base % 16], 3'b000);
        f_loop = 1'b0;
        repeat (20) @(negedge clk);

        // 3b: same frame with the parity bit forced to 1
        base = f_rx_cnt;
        f_send(8'hB1, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check("t3b_rx_count", f_rx_cnt, base + 1);
        check("t3b_rx_data", f_rx_dat[base % 16], 8'hB1);
        check("t3b_rx_flags", f_rx_flg[base % 16], 3'b010);
        repeat (2 * F_TXDIV) @(negedge clk);
        check("t3b_parerr_holds", f_rxParErr, 1'b1);

        // 4: 0x55 with stop bit low -> framing error only
        base = f_rx_cnt;
        f_send(8'h55, 1'b0, 1'b0);
        repeat (2 * F_TXDIV) @(negedge clk);
        check("t4_rx_count", f_rx_cnt, base + 1);
        check("t4_rx_data", f_rx_dat[base % 16], 8'h55);
        check("t4_rx_flags", f_rx_flg[base % 16], 3'b100);

        // 4b: line low for 12 bit times -> break
        base = f_rx_cnt;
        f_drive = 1'b0;
        low_n = 0;
        while (f_rx_cnt < base + 1 && low_n < 12 * F_TXDIV) begin
            @(negedge clk);
            low_n++;
        end
        check("t4b_rx_count", f_rx_cnt, base + 1);
        check("t4b_rx_data", f_rx_dat[base % 16], 8'h00);
        check("t4b_rx_flags", f_rx_flg[base % 16], 3'b101);
        repeat (12 * F_TXDIV - low_n) @(negedge clk);
        f_drive = 1'b1;
        f_rxEn = 1'b0;
        repeat (3) @(negedge clk);
        check("t4b_rxen_low_busy", f_rxBusy, 1'b0);
        check("t4b_flags_hold", {f_rxErr, f_rxParErr, f_rxBreak, f_rxOut}, {3'b101, 8'h00});
        f_rxEn = 1'b1;
        repeat (2 * F_TXDIV) @(negedge clk);

        // 5: 5-tick glitch -> busy pulse, no frame, flags unchanged
        base = f_rx_cnt;
        busy_seen = 1'b0;
        f_drive = 1'b0;
        repeat (10) begin
            @(negedge clk);
            busy_seen |= f_rxBusy;
        end
        f_drive = 1'b1;
        repeat (40) begin
            @(negedge clk);
            busy_seen |= f_rxBusy;
        end
        check("t5_busy_pulsed", busy_seen, 1'b1);
        check("t5_no_rxdone", f_rx_cnt, base);
        check("t5_busy_cleared", f_rxBusy, 1'b0);
        check("t5_flags_hold", {f_rxErr, f_rxParErr, f_rxBreak}, 3'b101);

        // 6: async reset in the middle of the data bits, then a clean 0x3C frame
        f_loop = 1'b1;
        repeat (4) @(negedge clk);
        launch(1'b1, 8'h00);
        repeat (2 * F_TXDIV + F_TXDIV / 2) @(negedge clk);
        check("t6_mid_data", {f_txOut, f_txBusy}, 2'b01);
        #2;
        f_rst = 1'b1;
        #1;
        check("t6_async_tx", {f_txOut, f_txBusy}, 2'b10);
        check("t6_async_rx", {f_rxBusy, f_rxErr, f_rxBreak, f_rxOut}, 11'h000);
        @(negedge clk);
        f_rst = 1'b0;
        repeat (4) @(negedge clk);
        base = f_rx_cnt;
        launch(1'b1, 8'h3C);
        wait_txdone(1'b1, 500, n);
        check("t6_txdone_latency", n, 11 * F_TXDIV);
        wait_rx(1'b1, base + 1, 100);
        check("t6_rx_count", f_rx_cnt, base + 1);
        check("t6_rx_data", f_rx_dat[base % 16], 8'h3C);
        check("t6_rx_flags", f_rx_flg[base % 16], 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_n.md
Name: uart_n

Overview:
- Parametrised full-duplex UART, successor to the fixed 8N1 Uart8.
- Configurable data width, parity mode, stop-bit count and baud rate.
- Adds parity-error and break detection, glitch-rejecting start detect, back-to-back transmission.
- Sits between host logic and the serial pins; one clock domain, tick enables instead of derived clocks.

Parameters:
- CLOCK_RATE, 12000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line rate in baud.
- DATA_BITS, 8: data bits per frame. Legal range 5..9.
- PARITY, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits per frame. Legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rxEn  input  1  receiver enable.
- rxIn  input  1  serial input, asynchronous to clk.
- rxBusy  output  1  frame reception in progress.
- rxDone  output  1  one-cycle pulse: frame received.
- rxErr  output  1  framing error (stop bit sampled low); valid with rxDone.
- rxParErr  output  1  parity mismatch; valid with rxDone.
- rxBreak  output  1  break: all data, parity and stop bits low; valid with rxDone.
- rxOut  output  DATA_BITS  last received data, LSB first on the wire.
- txEn  input  1  transmitter enable.
- txStart  input  1  level request to send txIn.
- txIn  input  DATA_BITS  data to send.
- txBusy  output  1  frame transmission in progress.
- txDone  output  1  one-cycle pulse at end of last stop bit.
- txOut  output  1  serial output; idle high.

Behaviour:
- Reset (asynchronous): txOut=1; rxOut=0; all other outputs 0; both FSMs to IDLE; counters cleared; rx synchroniser flops set to 1.
- Divisors, integer division: TX_DIV = CLOCK_RATE/BAUD_RATE and RX_DIV = CLOCK_RATE/(BAUD_RATE*16). RX tick is 16x oversampling.
- TX FSM, states IDLE→START→DATA→PARITY→STOP→IDLE:
  - PARITY is skipped when PARITY=0.
  - In IDLE, txEn && txStart latches txIn and clears the baud counter.
  - The next cycle drives txOut=0 and txBusy=1.
  - Each bit lasts exactly TX_DIV cycles. DATA shifts LSB first.
  - PARITY bit = XOR of data for even, inverted XOR for odd.
  - STOP drives 1 for STOP_BITS*TX_DIV cycles.
  - On the final stop cycle: txDone=1 for one cycle, txBusy falls, FSM returns to IDLE.
  - If txStart is still high in that IDLE cycle, the next frame's start bit follows immediately (back-to-back, no idle gap).
  - txEn low mid-frame aborts: txOut=1, txBusy=0 next cycle, no txDone.
- RX front end: 2-flop synchroniser on rxIn; the FSM sees the second flop only.
- RX FSM, states IDLE→START→DATA→PARITY→STOP→IDLE:
  - IDLE (rxEn=1): on sync low at an RX tick, enter START, rxBusy=1, tick count=0.
  - START: at the 8th tick (mid-bit), if the line is high it is a glitch. Return to IDLE with no flags raised.
  - DATA and PARITY: sample every 16 ticks (mid-bit), LSB first.
  - STOP: only the first stop bit is sampled, at mid-bit.
  - In the cycle after the stop sample: rxDone=1 for one cycle, rxOut updated, rxErr/rxParErr/rxBreak set.
  - The three flags hold until the next rxDone. rxBusy falls and the FSM returns to IDLE, allowing resync in the second half of the stop bit.
  - rxOut is updated even when errors are flagged.
- rxEn low: RX FSM forced to IDLE, rxBusy=0, no rxDone. rxOut and flags hold.
- Simultaneous TX and RX are fully independent.
- Elaboration: $error on DATA_BITS outside 5..9, PARITY>2, STOP_BITS∉{1,2}, or RX_DIV<1.

Decomposition:
- Package uart_pkg holds:
  - parity_e (NONE, ODD, EVEN);
  - tx_state_e and rx_state_e;
  - constant OVERSAMPLE=16;
  - function calc_div(clock, baud).
- Sub-module uart_tick_gen(DIV): free-running counter with synchronous clear, one-cycle tick output. Instantiated twice, once for TX and once for RX.

Test Plan:
1. Loopback 8N1, CLOCK_RATE=12e6, BAUD_RATE=9600, txIn=0x7A pulsed with txStart → txDone exactly 12500 cycles after acceptance; rxDone with rxOut=0x7A and rxErr/rxParErr/rxBreak=0.
2. txStart held high with txIn 0x7A then 0xB1 → second start bit immediately follows one TX_DIV stop period; rx gets 0x7A then 0xB1.
3. PARITY=2, txIn=0xB1 → parity bit 0, rxParErr=0. Force the received parity bit to 1 → rxParErr=1, rxOut=0xB1.
4. Drive a frame with stop bit low, data 0x55 → rxErr=1, rxBreak=0. Hold rxIn low for 12 bit times → rxDone with rxOut=0x00, rxErr=1, rxBreak=1.
5. rxIn low for 5 RX ticks then high → rxBusy pulses; no rxDone, flags unchanged.
6. Assert reset mid-frame (DATA state) → txOut=1 and txBusy=0 without a clock edge; after release, a new 0x3C frame completes normally.
